// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler feeding one tx_uart through a TX FIFO
module uart_tx_sched #(
    parameter int N_REQ = 2,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [8*N_REQ-1:0]           req_data,
    output logic [N_REQ-1:0]             req_ready,
    input  logic                         flush,
    output logic                         uart_valid,
    output logic [7:0]                   uart_data,
    input  logic                         uart_ready,
    input  logic                         uart_busy,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic                         fifo_empty,
    output logic                         fifo_full,
    output logic                         tx_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] rr_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [7:0]    mem [DEPTH];

    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx;
    logic [PW-1:0]    scan_idx;
    logic [7:0]       push_data;
    logic             found;
    logic             push;
    logic             pop;

    assign fifo_level = level;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == (AW+1)'(DEPTH));
    assign tx_idle    = (state == ST_IDLE) && fifo_empty && !uart_busy;
    assign req_ready  = grant;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant     = '0;
        grant_idx = rr_ptr;
        scan_idx  = '0;
        push_data = '0;
        found     = 1'b0;
        if (!reset && !fifo_full && !flush) begin
            for (int k = 1; k <= N_REQ; k++) begin
                scan_idx = PW'((int'(rr_ptr) + k) % N_REQ);
                if (!found && req_valid[scan_idx]) begin
                    found           = 1'b1;
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                    push_data       = req_data[8*int'(scan_idx) +: 8];
                end
            end
        end
    end

    assign push = found;
    assign pop  = (state == ST_IDLE) && !fifo_empty && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= PW'(N_REQ - 1);
        end else if (push) begin
            rr_ptr <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // GAP gives tx_uart the one cycle after done in which it ignores valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            uart_valid <= 1'b0;
            uart_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        uart_data  <= mem[rd_ptr];
                        uart_valid <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (uart_ready) begin
                        uart_valid <= 1'b0;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    uart_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    uart_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int N_REQ = 2;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_REQ-1:0] req_valid;
    logic [15:0]      req_data;
    logic [N_REQ-1:0] req_ready;
    logic             flush;
    logic             uart_valid;
    logic [7:0]       uart_data;
    logic             uart_ready;
    logic             uart_busy;
    logic [AW:0]      fifo_level;
    logic             fifo_empty;
    logic             fifo_full;
    logic             tx_idle;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .uart_valid(uart_valid),
        .uart_data(uart_data), .uart_ready(uart_ready), .uart_busy(uart_busy),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .tx_idle(tx_idle)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; req_data = '0; flush = 1'b0;
        uart_ready = 1'b0; uart_busy = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push_bytes(input int n, input logic [7:0] base);
        int done;
        int cyc;
        done = 0;
        cyc  = 0;
        while (done < n && cyc < 100) begin
            req_valid = 2'b01;
            req_data  = {8'h00, base + 8'(done)};
            half();
            if (req_ready[0]) begin
                exp_q.push_back(req_data[7:0]);
                done++;
            end
            step();
            cyc++;
        end
        req_valid = '0;
        checks++;
        if (done != n) begin errors++; $display("FAIL push_count got %0d exp %0d", done, n); end
    endtask

    task automatic send_one();
        int n;
        logic [7:0] e;
        n = 0;
        while (uart_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        checks++;
        if (uart_valid !== 1'b1 || uart_data !== e) begin
            errors++;
            $display("FAIL send_data got valid=%b data=%h exp valid=1 data=%h", uart_valid, uart_data, e);
        end
        uart_ready = 1'b1;
        step();
        uart_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b11; req_data = 16'h2211; flush = 1'b0;
        uart_ready = 1'b0; uart_busy = 1'b0;
        step();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", req_ready); end
        checks++; if (uart_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", uart_valid); end
        checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", uart_data); end
        checks++; if (fifo_level !== 5'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            errors++; $display("FAIL rst_fifo got lvl=%0d e=%b f=%b exp 0 1 0", fifo_level, fifo_empty, fifo_full); end
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", tx_idle); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 2'b01; req_data = 16'h00A5;
        half();
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", req_ready); end
        step();
        req_valid = '0;
        checks++; if (uart_valid !== 1'b0 || fifo_level !== 5'd1) begin
            errors++; $display("FAIL single_t1 got valid=%b lvl=%0d exp 0 1", uart_valid, fifo_level); end
        step();
        checks++; if (uart_valid !== 1'b1 || uart_data !== 8'hA5 || fifo_level !== 5'd0) begin
            errors++; $display("FAIL single_t2 got valid=%b data=%h lvl=%0d exp 1 a5 0", uart_valid, uart_data, fifo_level); end
        uart_busy = 1'b1;
        step();
        step();
        checks++; if (uart_valid !== 1'b1 || uart_data !== 8'hA5) begin
            errors++; $display("FAIL single_hold got valid=%b data=%h exp 1 a5", uart_valid, uart_data); end
        uart_ready = 1'b1;
        step();
        uart_ready = 1'b0;
        checks++; if (uart_valid !== 1'b0 || tx_idle !== 1'b0) begin
            errors++; $display("FAIL single_gap got valid=%b idle=%b exp 0 0", uart_valid, tx_idle); end
        uart_busy = 1'b0;
        step();
        checks++; if (uart_valid !== 1'b0 || tx_idle !== 1'b1) begin
            errors++; $display("FAIL single_idle got valid=%b idle=%b exp 0 1", uart_valid, tx_idle); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        do_reset();
        req_valid = 2'b11; req_data = 16'h2211;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            half();
            checks++; if (req_ready !== exp_g) begin
                errors++; $display("FAIL rr_grant%0d got %b exp %b", i, req_ready, exp_g); end
            exp_q.push_back((i % 2 == 1) ? 8'h22 : 8'h11);
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) send_one();
    endtask

    task automatic test_backpressure();
        int acc;
        do_reset();
        acc = 0;
        for (int i = 0; i < 17; i++) begin
            req_valid = 2'b01; req_data = {8'h00, 8'(i)};
            half();
            if (req_ready === 2'b01) acc++;
            step();
        end
        req_data = 16'h0099;
        checks++; if (acc != 17) begin errors++; $display("FAIL bp_accepted got %0d exp 17", acc); end
        checks++; if (fifo_level !== 5'd16 || fifo_full !== 1'b1 || uart_data !== 8'h00) begin
            errors++; $display("FAIL bp_full got lvl=%0d full=%b data=%h exp 16 1 00", fifo_level, fifo_full, uart_data); end
        step(); step(); step();
        half();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_held got %b exp 00", req_ready); end
        uart_ready = 1'b1;
        step();
        uart_ready = 1'b0;
        step();
        half();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_full_pop got %b exp 00", req_ready); end
        step();
        half();
        checks++; if (req_ready !== 2'b01 || fifo_level !== 5'd15 || uart_data !== 8'h01) begin
            errors++; $display("FAIL bp_release got rdy=%b lvl=%0d data=%h exp 01 15 01", req_ready, fifo_level, uart_data); end
        step();
        req_valid = '0;
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL bp_refill got %0d exp 16", fifo_level); end
    endtask

    task automatic test_pushpop_wrap();
        logic [7:0] e;
        int n;
        do_reset();
        push_bytes(6, 8'h40);
        checks++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL pp_level5 got %0d exp 5", fifo_level); end
        e = exp_q.pop_front();
        checks++; if (uart_valid !== 1'b1 || uart_data !== e) begin
            errors++; $display("FAIL pp_first got valid=%b data=%h exp 1 %h", uart_valid, uart_data, e); end
        uart_ready = 1'b1;
        step();
        uart_ready = 1'b0;
        step();
        req_valid = 2'b01; req_data = 16'h0050;
        half();
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL pp_grant got %b exp 01", req_ready); end
        exp_q.push_back(8'h50);
        step();
        req_valid = '0;
        checks++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL pp_same_cycle got %0d exp 5", fifo_level); end
        push_bytes(10, 8'h60);
        checks++; if (fifo_level !== 5'd15) begin errors++; $display("FAIL pp_level15 got %0d exp 15", fifo_level); end
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            send_one();
            n++;
        end
        step(); step(); step();
        checks++; if (fifo_level !== 5'd0 || fifo_empty !== 1'b1 || uart_valid !== 1'b0) begin
            errors++; $display("FAIL pp_drained got lvl=%0d e=%b v=%b exp 0 1 0", fifo_level, fifo_empty, uart_valid); end
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        push_bytes(5, 8'h70);
        exp_q.delete();
        checks++; if (fifo_level !== 5'd4 || uart_valid !== 1'b1) begin
            errors++; $display("FAIL fl_pre got lvl=%0d v=%b exp 4 1", fifo_level, uart_valid); end
        flush = 1'b1; req_valid = 2'b01; req_data = 16'h0099;
        half();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL fl_no_push got %b exp 00", req_ready); end
        step();
        flush = 1'b0; req_valid = '0;
        checks++; if (fifo_level !== 5'd0 || fifo_empty !== 1'b1) begin
            errors++; $display("FAIL fl_level got %0d e=%b exp 0 1", fifo_level, fifo_empty); end
        checks++; if (uart_valid !== 1'b1 || uart_data !== 8'h70) begin
            errors++; $display("FAIL fl_inflight got v=%b data=%h exp 1 70", uart_valid, uart_data); end
        uart_ready = 1'b1;
        step();
        uart_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (uart_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0 || tx_idle !== 1'b1) begin
            errors++; $display("FAIL fl_quiet got valid_cycles=%0d idle=%b exp 0 1", seen, tx_idle); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_bytes(2, 8'h81);
        exp_q.delete();
        checks++; if (uart_valid !== 1'b1 || uart_data !== 8'h81) begin
            errors++; $display("FAIL rm_send got v=%b data=%h exp 1 81", uart_valid, uart_data); end
        req_valid = 2'b01; req_data = 16'h0055;
        #3;
        reset = 1'b1;
        #1;
        checks++; if (uart_valid !== 1'b0 || uart_data !== 8'h00 || fifo_level !== 5'd0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rm_async got v=%b data=%h lvl=%0d rdy=%b exp 0 00 0 00", uart_valid, uart_data, fifo_level, req_ready); end
        step();
        reset = 1'b0;
        req_valid = 2'b01; req_data = 16'h003C;
        half();
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_grant got %b exp 01", req_ready); end
        step();
        req_valid = '0;
        step();
        checks++; if (uart_valid !== 1'b1 || uart_data !== 8'h3C) begin
            errors++; $display("FAIL rm_first got v=%b data=%h exp 1 3c", uart_valid, uart_data); end
        uart_ready = 1'b1;
        step();
        uart_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_pushpop_wrap();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
